// File: rtl/cpu_run_controller.sv
// Run/halt/single-step sequencer for the single-cycle RISC-V core.
// Conditions the board switch/button, gates core commits via cpu_en and counts retired cycles.
module cpu_run_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [31:0] EBREAK_WORD     = 32'h00100073
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic [31:0] instruction,
    output logic        cpu_en,
    output logic [1:0]  state,
    output logic [2:0]  halt_cause,
    output logic [31:0] retired_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] CAUSE_RESET = 3'd0;
    localparam logic [2:0] CAUSE_USER  = 3'd1;
    localparam logic [2:0] CAUSE_STEP  = 3'd2;
    localparam logic [2:0] CAUSE_BP    = 3'd3;
    localparam logic [2:0] CAUSE_EBRK  = 3'd4;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    // Channel 0 is the run switch, channel 1 the step button.
    logic [1:0]            w_raw;
    logic [1:0]            r_sync1;
    logic [1:0]            r_sync2;
    logic [1:0]            r_deb;
    logic [1:0]            r_deb_prev;
    logic [1:0][CNT_W-1:0] r_cnt;

    state_t      r_state;
    logic [2:0]  r_halt_cause;
    logic        r_skip;
    logic [31:0] r_retired_count;

    logic        w_run_rise;
    logic        w_step_rise;
    logic        w_halt_now;
    logic [2:0]  w_halt_cause;
    logic        w_cpu_en;

    assign w_raw = {step_btn, run_sw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_deb      <= '0;
            r_deb_prev <= '0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= w_raw;
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_MAX) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_run_rise  = r_deb[0] & ~r_deb_prev[0];
    assign w_step_rise = r_deb[1] & ~r_deb_prev[1];

    // Skip suppresses break checks on the first cycle so a resume at the break PC advances.
    always_comb begin
        w_halt_now   = 1'b0;
        w_halt_cause = CAUSE_RESET;
        if (r_state == ST_RUN && !r_skip) begin
            if (instruction == EBREAK_WORD) begin
                w_halt_now   = 1'b1;
                w_halt_cause = CAUSE_EBRK;
            end else if (bp_en && pc == bp_addr) begin
                w_halt_now   = 1'b1;
                w_halt_cause = CAUSE_BP;
            end else if (!r_deb[0]) begin
                w_halt_now   = 1'b1;
                w_halt_cause = CAUSE_USER;
            end
        end
    end

    assign w_cpu_en = (r_state == ST_RUN && !w_halt_now) || (r_state == ST_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_HALT;
            r_halt_cause    <= CAUSE_RESET;
            r_skip          <= 1'b0;
            r_retired_count <= '0;
        end else begin
            if (w_cpu_en) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
            case (r_state)
                ST_HALT: begin
                    if (w_run_rise) begin
                        r_state <= ST_RUN;
                        r_skip  <= 1'b1;
                    end else if (w_step_rise) begin
                        r_state <= ST_STEP;
                        r_skip  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_halt_now) begin
                        r_state      <= ST_HALT;
                        r_halt_cause <= w_halt_cause;
                    end else begin
                        r_skip <= 1'b0;
                    end
                end
                ST_STEP: begin
                    r_state      <= ST_HALT;
                    r_halt_cause <= CAUSE_STEP;
                    r_skip       <= 1'b0;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    assign cpu_en        = w_cpu_en;
    assign state         = r_state;
    assign halt_cause    = r_halt_cause;
    assign retired_count = r_retired_count;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed scenarios plus random switch/button traffic,
// compared every cycle against a behavioural model of the run/halt/step rules.
module tb_cpu_run_controller;

    localparam int DB = 4;
    localparam logic [31:0] EBRK = 32'h00100073;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        run_sw;
    logic        step_btn;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic [31:0] ebreak_pc;
    logic        cpu_en;
    logic [1:0]  state;
    logic [2:0]  halt_cause;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_err    = 0;
    int en_seen  = 0;
    bit chk_on   = 1'b0;

    // Behavioural model state
    int          m_mode  = 0;   // 0 halt, 1 run, 2 step
    int          m_cause = 0;
    logic [31:0] m_count = 0;
    bit          m_skip  = 0;
    bit          m_deb  [2];
    bit          m_prev [2];
    bit          m_hist [2][0:DB];
    bit          core_commit = 0;

    cpu_run_controller #(.DEBOUNCE_CYCLES(DB), .EBREAK_WORD(EBRK)) dut (
        .clk          (clk),
        .rst          (rst),
        .run_sw       (run_sw),
        .step_btn     (step_btn),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .pc           (pc),
        .instruction  (instruction),
        .cpu_en       (cpu_en),
        .state        (state),
        .halt_cause   (halt_cause),
        .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    assign instruction = (pc == ebreak_pc) ? EBRK : NOP;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int m_halt_code();
        if (m_mode == 1 && !m_skip) begin
            if (instruction == EBRK) return 4;
            if (bp_en && pc == bp_addr) return 3;
            if (!m_deb[0]) return 1;
        end
        return 0;
    endfunction

    function automatic bit m_en();
        return (m_mode == 1 && m_halt_code() == 0) || m_mode == 2;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_cause = 0; m_count = 0; m_skip = 0; core_commit = 0;
            for (int c = 0; c < 2; c++) begin
                m_deb[c] = 0; m_prev[c] = 0;
                for (int k = 0; k <= DB; k++) m_hist[c][k] = 0;
            end
        end else begin
            automatic bit en = m_en();
            automatic int hc = m_halt_code();
            automatic bit rr = m_deb[0] && !m_prev[0];
            automatic bit sr = m_deb[1] && !m_prev[1];
            automatic bit raw [2];
            raw[0] = run_sw;
            raw[1] = step_btn;
            core_commit = en;
            if (en) m_count = m_count + 1;
            case (m_mode)
                0: if (rr) begin m_mode = 1; m_skip = 1; end
                   else if (sr) begin m_mode = 2; m_skip = 1; end
                1: if (hc != 0) begin m_mode = 0; m_cause = hc; end
                   else m_skip = 0;
                default: begin m_mode = 0; m_cause = 2; m_skip = 0; end
            endcase
            // A level is accepted once the last DB synchronized samples all disagree with it.
            for (int c = 0; c < 2; c++) begin
                automatic bit all_diff = 1;
                m_prev[c] = m_deb[c];
                for (int k = 1; k <= DB; k++) if (m_hist[c][k] == m_deb[c]) all_diff = 0;
                if (all_diff) m_deb[c] = !m_deb[c];
                for (int k = DB; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
                m_hist[c][0] = raw[c];
            end
        end
    end

    always @(negedge clk) begin
        if (cpu_en === 1'b1) en_seen++;
        if (chk_on && !rst) begin
            chk("cyc_cpu_en", {31'd0, cpu_en}, {31'd0, m_en()});
            chk("cyc_state", {30'd0, state}, m_mode);
            chk("cyc_cause", {29'd0, halt_cause}, m_cause);
            chk("cyc_count", retired_count, m_count);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (core_commit) pc = pc + 32'd4;
        end
    endtask

    initial begin
        int w;
        rst = 1'b0; run_sw = 0; step_btn = 0; bp_en = 0; bp_addr = 0;
        pc = 0; ebreak_pc = 32'hFFFF_FFF0;
        #1 rst = 1'b1;
        #20 rst = 1'b0;
        chk_on = 1'b1;
        cycles(20);
        chk("rst_state", {30'd0, state}, 0);
        chk("rst_cpu_en", {31'd0, cpu_en}, 0);
        chk("rst_cause", {29'd0, halt_cause}, 0);
        chk("rst_count", retired_count, 0);

        // Single step, then a glitch that must be rejected
        en_seen = 0;
        step_btn = 1; cycles(10);
        step_btn = 0; cycles(10);
        chk("step_en_cycles", en_seen, 1);
        chk("step_state", {30'd0, state}, 0);
        chk("step_cause", {29'd0, halt_cause}, 2);
        chk("step_count", retired_count, 1);
        en_seen = 0;
        step_btn = 1; cycles(2);
        step_btn = 0; cycles(12);
        chk("glitch_en_cycles", en_seen, 0);
        chk("glitch_count", retired_count, 1);

        // Breakpoint at 0x10
        pc = 0; bp_en = 1; bp_addr = 32'h10; run_sw = 1;
        cycles(20);
        chk("bp_cause", {29'd0, halt_cause}, 3);
        chk("bp_count", retired_count, 5);
        chk("bp_pc", pc, 32'h10);
        chk("bp_cpu_en", {31'd0, cpu_en}, 0);
        cycles(10);
        chk("bp_hold_state", {30'd0, state}, 0);
        chk("bp_hold_count", retired_count, 5);
        run_sw = 0; cycles(10);
        run_sw = 1;
        w = 0;
        while (state !== 2'd1 && w < 20) begin cycles(1); w++; end
        chk("resume_state", {30'd0, state}, 1);
        cycles(1);
        chk("resume_count", retired_count, 6);

        // EBREAK wins over a breakpoint on the same PC
        bp_addr = 32'h20; ebreak_pc = 32'h20;
        cycles(10);
        chk("ebrk_cause", {29'd0, halt_cause}, 4);
        chk("ebrk_state", {30'd0, state}, 0);
        chk("ebrk_count", retired_count, 9);

        // User halt by dropping the run switch
        run_sw = 0; cycles(8);
        run_sw = 1; cycles(10);
        ebreak_pc = 32'hFFFF_FFF0; bp_en = 0;
        cycles(4);
        run_sw = 0; cycles(5);
        chk("user_still_run", {30'd0, state}, 1);
        cycles(2);
        chk("user_state", {30'd0, state}, 0);
        chk("user_cause", {29'd0, halt_cause}, 1);

        // Run and step rising together: run wins
        run_sw = 1; step_btn = 1; cycles(10);
        chk("simul_state", {30'd0, state}, 1);
        run_sw = 0; step_btn = 0; cycles(10);

        // Counter wrap
        force dut.r_retired_count = 32'hFFFF_FFFE;
        m_count = 32'hFFFF_FFFE;
        #1 release dut.r_retired_count;
        chk("wrap_preload", retired_count, 32'hFFFF_FFFE);
        repeat (3) begin
            step_btn = 1; cycles(8);
            step_btn = 0; cycles(8);
        end
        chk("wrap_count", retired_count, 1);

        // Asynchronous reset in the middle of a running cycle
        run_sw = 1; cycles(10);
        chk("arst_pre_state", {30'd0, state}, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_cpu_en", {31'd0, cpu_en}, 0);
        chk("arst_count", retired_count, 0);
        chk("arst_state", {30'd0, state}, 0);
        chk("arst_cause", {29'd0, halt_cause}, 0);
        cycles(2);
        rst = 1'b0; pc = 0;

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) run_sw = ~run_sw;
            if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
            if (i % 40 == 0) begin
                bp_en     = $urandom_range(0, 1);
                bp_addr   = 32'($urandom_range(0, 16)) << 2;
                ebreak_pc = ($urandom_range(0, 2) == 0) ? (32'($urandom_range(0, 16)) << 2) : 32'hFFFF_FFF0;
            end
            if (pc > 32'h40) pc = 0;
            cycles(1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
